// File: rtl/completion_buffer.sv
// In-order completion buffer: takes 2 dispatches per cycle, tracks finish status and retires up to 2 per cycle.
// Outputs depend on registered state only; a finish becomes retirable one cycle after it is reported.
module completion_buffer #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_en_A,
  input  logic              disp_dest_en_A,
  input  logic [ADDR_W-1:0] disp_dest_A,
  input  logic              disp_en_B,
  input  logic              disp_dest_en_B,
  input  logic [ADDR_W-1:0] disp_dest_B,
  output logic              disp_ready_A,
  output logic              disp_ready_B,
  output logic [IDX_W-1:0]  disp_tag_A,
  output logic [IDX_W-1:0]  disp_tag_B,
  input  logic              fin_en_A,
  input  logic [IDX_W-1:0]  fin_tag_A,
  input  logic              fin_en_B,
  input  logic [IDX_W-1:0]  fin_tag_B,
  output logic              update_en_A,
  output logic [ADDR_W-1:0] update_addr_A,
  output logic              update_en_B,
  output logic [ADDR_W-1:0] update_addr_B,
  output logic [1:0]        retire_cnt,
  output logic [IDX_W:0]    occupancy
);

  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0]    FULL      = CW'(DEPTH);
  localparam logic [CW-1:0]    TWO_SHORT = CW'(DEPTH - 2);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  finished;
  logic [DEPTH-1:0]  dest_en;
  logic [ADDR_W-1:0] dest [DEPTH];
  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [CW-1:0]     count;

  logic [IDX_W-1:0] head1;
  logic [IDX_W-1:0] tail1;
  logic             ret_a;
  logic             ret_b;
  logic             same_dest;
  logic             acc_a;
  logic             acc_b;
  logic [1:0]       acc_cnt;

  assign head1 = head + ONE;
  assign tail1 = tail + ONE;

  // Two retirements to the same ARF register in one cycle would collide at the
  // register file, so the younger one waits a cycle.
  assign same_dest = dest_en[head] && dest_en[head1] && (dest[head] == dest[head1]);
  assign ret_a     = valid[head] && finished[head];
  assign ret_b     = ret_a && valid[head1] && finished[head1] && !same_dest;

  assign update_en_A   = ret_a && dest_en[head];
  assign update_addr_A = update_en_A ? dest[head] : '0;
  assign update_en_B   = ret_b && dest_en[head1];
  assign update_addr_B = update_en_B ? dest[head1] : '0;
  assign retire_cnt    = {1'b0, ret_a} + {1'b0, ret_b};

  assign disp_ready_A = (count != FULL);
  assign disp_ready_B = (count <= TWO_SHORT);
  assign disp_tag_A   = tail;
  assign disp_tag_B   = tail1;
  assign occupancy    = count;

  assign acc_a   = disp_en_A && disp_ready_A;
  assign acc_b   = acc_a && disp_en_B && disp_ready_B;
  assign acc_cnt = {1'b0, acc_a} + {1'b0, acc_b};

  // Order matters: finish, then retire-clear, then dispatch-write; the slots a
  // dispatch writes are never the ones being retired because they were free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      finished <= '0;
      dest_en  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (fin_en_A && valid[fin_tag_A]) finished[fin_tag_A] <= 1'b1;
      if (fin_en_B && valid[fin_tag_B]) finished[fin_tag_B] <= 1'b1;
      if (ret_a) begin
        valid[head]    <= 1'b0;
        finished[head] <= 1'b0;
      end
      if (ret_b) begin
        valid[head1]    <= 1'b0;
        finished[head1] <= 1'b0;
      end
      if (acc_a) begin
        valid[tail]    <= 1'b1;
        finished[tail] <= 1'b0;
        dest_en[tail]  <= disp_dest_en_A;
      end
      if (acc_b) begin
        valid[tail1]    <= 1'b1;
        finished[tail1] <= 1'b0;
        dest_en[tail1]  <= disp_dest_en_B;
      end
      head  <= head + IDX_W'(retire_cnt);
      tail  <= tail + IDX_W'(acc_cnt);
      count <= count + CW'(acc_cnt) - CW'(retire_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (acc_a) dest[tail]  <= disp_dest_A;
    if (acc_b) dest[tail1] <= disp_dest_B;
  end

endmodule

// File: tb/tb_completion_buffer.sv
// Directed bench for completion_buffer: dispatch, finish, paired/deferred retire, full, wrap and reset.
module tb_completion_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       disp_en_A, disp_dest_en_A, disp_en_B, disp_dest_en_B;
  logic [4:0] disp_dest_A, disp_dest_B;
  logic       disp_ready_A, disp_ready_B;
  logic [2:0] disp_tag_A, disp_tag_B;
  logic       fin_en_A, fin_en_B;
  logic [2:0] fin_tag_A, fin_tag_B;
  logic       update_en_A, update_en_B;
  logic [4:0] update_addr_A, update_addr_B;
  logic [1:0] retire_cnt;
  logic [3:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;

  completion_buffer #(.DEPTH(8), .IDX_W(3), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_en_A(disp_en_A), .disp_dest_en_A(disp_dest_en_A), .disp_dest_A(disp_dest_A),
    .disp_en_B(disp_en_B), .disp_dest_en_B(disp_dest_en_B), .disp_dest_B(disp_dest_B),
    .disp_ready_A(disp_ready_A), .disp_ready_B(disp_ready_B),
    .disp_tag_A(disp_tag_A), .disp_tag_B(disp_tag_B),
    .fin_en_A(fin_en_A), .fin_tag_A(fin_tag_A), .fin_en_B(fin_en_B), .fin_tag_B(fin_tag_B),
    .update_en_A(update_en_A), .update_addr_A(update_addr_A),
    .update_en_B(update_en_B), .update_addr_B(update_addr_B),
    .retire_cnt(retire_cnt), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    disp_en_A = 1'b0; disp_dest_en_A = 1'b0; disp_dest_A = '0;
    disp_en_B = 1'b0; disp_dest_en_B = 1'b0; disp_dest_B = '0;
    fin_en_A = 1'b0; fin_tag_A = '0; fin_en_B = 1'b0; fin_tag_B = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic ena, input logic dea, input logic [4:0] da,
                      input logic enb, input logic deb, input logic [4:0] db);
    disp_en_A = ena; disp_dest_en_A = dea; disp_dest_A = da;
    disp_en_B = enb; disp_dest_en_B = deb; disp_dest_B = db;
  endtask

  task automatic fin(input logic ea, input logic [2:0] ta, input logic eb, input logic [2:0] tb);
    fin_en_A = ea; fin_tag_A = ta; fin_en_B = eb; fin_tag_B = tb;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_occ", 32'(occupancy), 0);
    check("rst_rdyA", 32'(disp_ready_A), 1);
    check("rst_rdyB", 32'(disp_ready_B), 1);
    check("rst_tagA", 32'(disp_tag_A), 0);
    check("rst_tagB", 32'(disp_tag_B), 1);
    check("rst_upd", 32'({update_en_A, update_en_B, update_addr_A, update_addr_B}), 0);
    check("rst_rcnt", 32'(retire_cnt), 0);
    tick();
    rst_n = 1'b1;

    // Pair dispatch, out-of-order finish, paired retire
    disp(1, 1, 5'd5, 1, 1, 5'd6);
    check("t1_tagA", 32'(disp_tag_A), 0);
    check("t1_tagB", 32'(disp_tag_B), 1);
    tick(); idle();
    check("t1_occ", 32'(occupancy), 2);
    fin(1, 3'd1, 0, 3'd0);
    tick(); idle();
    check("t1_noret", 32'(retire_cnt), 0);
    check("t1_noupd", 32'(update_en_A), 0);
    fin(1, 3'd0, 0, 3'd0);
    tick(); idle();
    check("t1_enA", 32'(update_en_A), 1);
    check("t1_addrA", 32'(update_addr_A), 5);
    check("t1_enB", 32'(update_en_B), 1);
    check("t1_addrB", 32'(update_addr_B), 6);
    check("t1_rcnt", 32'(retire_cnt), 2);
    tick();
    check("t1_occ0", 32'(occupancy), 0);
    check("t1_empty_rcnt", 32'(retire_cnt), 0);

    // B without A is ignored
    disp(0, 1, 5'd9, 1, 1, 5'd9);
    tick(); idle();
    check("bonly_occ", 32'(occupancy), 0);

    // Fill to full from a clean reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      disp(1, 1, 5'(2 * k + 1), 1, 1, 5'(2 * k + 2));
      check($sformatf("fill_tag%0d", k), 32'(disp_tag_A), 32'(2 * k));
      tick();
    end
    check("full_occ", 32'(occupancy), 8);
    check("full_rdyA", 32'(disp_ready_A), 0);
    check("full_rdyB", 32'(disp_ready_B), 0);
    check("full_tagA", 32'(disp_tag_A), 0);
    tick(); idle();
    check("full_ign_occ", 32'(occupancy), 8);
    check("full_ign_tag", 32'(disp_tag_A), 0);

    // Retire one from full; same-cycle dispatch is refused, then lands at wrapped tag 0
    fin(1, 3'd0, 0, 3'd0);
    tick(); idle();
    check("fr_rcnt", 32'(retire_cnt), 1);
    check("fr_addrA", 32'(update_addr_A), 1);
    check("fr_rdyA", 32'(disp_ready_A), 0);
    disp(1, 1, 5'd9, 0, 0, 5'd0);
    tick();
    check("fr_occ7", 32'(occupancy), 7);
    check("fr_rdyA1", 32'(disp_ready_A), 1);
    check("fr_wraptag", 32'(disp_tag_A), 0);
    tick(); idle();
    check("fr_occ8", 32'(occupancy), 8);
    check("fr_tail", 32'(disp_tag_A), 1);

    // No-destination head, then same-destination deferral
    do_reset();
    disp(1, 0, 5'd3, 1, 1, 5'd7);
    tick();
    disp(1, 1, 5'd7, 1, 1, 5'd4);
    tick(); idle();
    check("nd_occ", 32'(occupancy), 4);
    fin(1, 3'd0, 1, 3'd0);
    tick(); idle();
    check("nd_rcnt", 32'(retire_cnt), 1);
    check("nd_enA", 32'(update_en_A), 0);
    check("nd_addrA", 32'(update_addr_A), 0);
    check("nd_enB", 32'(update_en_B), 0);
    fin(1, 3'd1, 1, 3'd2);
    tick(); idle();
    check("sd_rcnt", 32'(retire_cnt), 1);
    check("sd_enA", 32'(update_en_A), 1);
    check("sd_addrA", 32'(update_addr_A), 7);
    check("sd_enB", 32'(update_en_B), 0);
    check("sd_occ", 32'(occupancy), 3);
    fin(1, 3'd3, 0, 3'd0);
    tick(); idle();
    check("sd2_rcnt", 32'(retire_cnt), 2);
    check("sd2_addrA", 32'(update_addr_A), 7);
    check("sd2_addrB", 32'(update_addr_B), 4);
    tick();
    check("sd_empty", 32'(occupancy), 0);

    // Finish to an empty slot has no lasting effect
    fin(1, 3'd5, 0, 3'd0);
    tick(); idle();
    disp(1, 1, 5'd10, 1, 1, 5'd11);
    check("inv_tagA", 32'(disp_tag_A), 4);
    tick(); idle();
    fin(1, 3'd4, 0, 3'd0);
    tick(); idle();
    check("inv_rcnt", 32'(retire_cnt), 1);
    check("inv_addr", 32'(update_addr_A), 10);

    // Mid-operation async reset with 5 valid entries
    disp(1, 1, 5'd12, 1, 1, 5'd13);
    tick();
    disp(1, 1, 5'd14, 1, 1, 5'd15);
    fin(1, 3'd5, 0, 3'd0);
    tick(); idle();
    check("mr_occ5", 32'(occupancy), 5);
    check("mr_enA", 32'(update_en_A), 1);
    check("mr_addrA", 32'(update_addr_A), 11);
    #2 rst_n = 1'b0;
    #1;
    check("mr_occ0", 32'(occupancy), 0);
    check("mr_upd0", 32'(update_en_A), 0);
    check("mr_rcnt0", 32'(retire_cnt), 0);
    tick();
    rst_n = 1'b1;
    disp(1, 1, 5'd2, 0, 0, 5'd0);
    check("mr_tag0", 32'(disp_tag_A), 0);
    tick(); idle();
    check("mr_occ1", 32'(occupancy), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
